load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max cycles in MEM state awaiting mem_ready (legal range 2..255).
REQ-002 Parameter RF_AW, default 4, meaning register-file write-address width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  operation valid, sampled only in IDLE.
REQ-006 type_code  input  2  00 ALU writeback, 01 load, 10 store, 11 reserved.
REQ-007 alu_result  input  32  signed ALU result; data for type 00, byte address for 01/10.
REQ-008 alu_negative, alu_zero  input  1 each  ALU flags for alu_result.
REQ-009 store_data  input  32  word to write on store.
REQ-010 rd_addr  input  RF_AW  destination register for ALU/load.
REQ-011 mem_req, mem_we  output  1 each  memory request / write enable.
REQ-012 mem_addr, mem_wdata  output  32 each  memory address / write data.
REQ-013 mem_ready  input  1  memory completion; mem_rdata  input  32  load data, valid with mem_ready.
REQ-014 rf_we  output  1; rf_waddr  output  RF_AW; rf_wdata  output  32  register-file write port.
REQ-015 flag_n, flag_z  output  1 each  architectural N/Z flags.
REQ-016 busy  output  1; done  output  1  one-cycle completion pulse; err  output  1  valid with done.

Function
REQ-017 States: IDLE, MEM, WB; busy SHALL be 1 in every state except IDLE.
REQ-018 In IDLE at an edge with start=1, inputs SHALL be latched (type, alu_result, flags, store_data, rd_addr); start outside IDLE SHALL be ignored.
REQ-019 Type 00: IDLE->WB; in WB rf_we=1, rf_wdata=latched alu_result, done=1, err=0; flag_n/flag_z SHALL update at the same acceptance edge.
REQ-020 Types 01/10 with latched address[1:0]=00: IDLE->MEM; in MEM mem_req=1, mem_addr=latched address, mem_we=1 for store only, mem_wdata=latched store_data.
REQ-021 In MEM, edge with mem_ready=1: load SHALL capture mem_rdata, go WB with rf_we=1, rf_wdata=captured word; store SHALL go WB with rf_we=0; err=0.
REQ-022 Timeout: counter cleared on MEM entry, incremented each MEM edge; at the TIMEOUT-th MEM edge without mem_ready, go WB with err=1, rf_we=0.
REQ-023 mem_ready on the same edge as timeout SHALL win (normal completion).
REQ-024 Misaligned load/store (address[1:0]!=00) or type 11: IDLE->WB, no memory request, rf_we=0, err=1.
REQ-025 WB lasts exactly one cycle, then IDLE; done is high only in WB.
REQ-026 Flags SHALL change only on accepted type-00 operations; loads/stores/errors leave them unchanged.
REQ-027 mem_ready outside MEM SHALL be ignored; mem_req SHALL be 0 outside MEM.
REQ-028 Latency: ALU 1 cycle after acceptance; load/store = cycles in MEM + 1; minimum issue interval 2 cycles.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, clear counter, and drive busy, done, err, mem_req, mem_we, rf_we, flag_n, flag_z to 0 and mem_addr, mem_wdata, rf_wdata, rf_waddr to 0.
REQ-030 Reset during MEM SHALL abandon the access with no writeback; a start sampled with reset=1 SHALL be ignored.

Structure
REQ-031 Type-code constants (ALU/LOAD/STORE/RSVD) and state encodings SHALL live in shared package cpu_pkg, also used by the ALU and decoder.
REQ-032 Timeout counting SHALL be one sub-module, lsu_timeout_counter (clear, enable, expired output, TIMEOUT parameter).

Verification
REQ-033 ALU: start, type 00, alu_result=-5, negative=1, rd_addr=3 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0xFFFFFFFB, done=1, flag_n=1, flag_z=0.
REQ-034 Load: type 01, address 0x100, mem_ready after 3 MEM cycles with rdata 0xDEADBEEF -> mem_addr=0x100, mem_we=0, then rf_wdata=0xDEADBEEF, done=1, err=0, flags unchanged.
REQ-035 Store: type 10, address 0x40, store_data 0x12345678, ready on first MEM cycle -> mem_we=1, mem_wdata=0x12345678, done=1, rf_we=0.
REQ-036 Timeout: TIMEOUT=4, mem_ready held 0 -> mem_req high 4 cycles, then done=1, err=1, rf_we=0; repeat with ready on 4th edge -> err=0.
REQ-037 Misaligned load at 0x102 and type 11 -> no mem_req, done=1, err=1 one cycle after acceptance.
REQ-038 Reset asserted in 2nd MEM cycle -> next cycle busy=0, mem_req=0, no done/rf_we; start during busy ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: operation type codes and load/store unit FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package cpu_pkg;

  typedef enum logic [1:0] {
    TYPE_ALU   = 2'b00,
    TYPE_LOAD  = 2'b01,
    TYPE_STORE = 2'b10,
    TYPE_RSVD  = 2'b11
  } type_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_WB   = 2'b10
  } lsu_state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory request bus between the load/store unit and memory.
// Request is held until mem_ready completes it; rdata is valid with mem_ready.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_timeout_counter.sv
// Counts MEM-state cycles; expired flags the TIMEOUT-th enabled edge.
// Combinational expired, one flop stage of count; no backpressure.
module lsu_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of MEM edges already taken, so this edge is number cnt_q+1
  assign expired = enable && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/load_store_unit.sv
// Executes ALU writeback, load and store ops: ALU/error 1 cycle, memory ops MEM cycles + 1.
// Accepts start only when idle; a memory access waits for mem_ready or gives up after TIMEOUT.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RF_AW   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         type_code,
  input  logic [31:0]        alu_result,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic [31:0]        store_data,
  input  logic [RF_AW-1:0]   rd_addr,
  load_store_unit_if.master  mem,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               flag_n,
  output logic               flag_z,
  output logic               busy,
  output logic               done,
  output logic               err
);

  lsu_state_t       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             is_load_q, is_load_d;
  logic             rf_we_q, rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             expired;
  type_code_t       op;

  assign op = type_code_t'(type_code);

  lsu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != ST_MEM),
    .enable  (state_q == ST_MEM),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    is_load_d   = is_load_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rf_waddr_d = rd_addr;
          is_load_d  = (op == TYPE_LOAD);
          if (op == TYPE_ALU) begin
            state_d    = ST_WB;
            rf_we_d    = 1'b1;
            rf_wdata_d = alu_result;
            flag_n_d   = alu_negative;
            flag_z_d   = alu_zero;
            done_d     = 1'b1;
          end else if ((op == TYPE_LOAD || op == TYPE_STORE) && is_word_aligned(alu_result)) begin
            state_d     = ST_MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = (op == TYPE_STORE);
            mem_addr_d  = alu_result;
            mem_wdata_d = store_data;
          end else begin
            state_d = ST_WB;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_MEM: begin
        // mem_ready is checked first so a completion on the expiry edge still succeeds
        if (mem.mem_ready) begin
          state_d = ST_WB;
          done_d  = 1'b1;
          rf_we_d = is_load_q;
          if (is_load_q) begin
            rf_wdata_d = mem.mem_rdata;
          end
        end else if (expired) begin
          state_d = ST_WB;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      is_load_q   <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      is_load_q   <= is_load_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign flag_n        = flag_n_q;
  assign flag_z        = flag_z_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
